// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: data width, NOP encoding and the fetch FIFO entry.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned OPC_W      = 4;
    localparam int unsigned REG_W      = 6;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Two-entry prefetch FIFO of {pc, inst} pairs; flush wins over push.
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       din,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head
);

    fetch_entry_t       mem_q [FIFO_DEPTH];
    fetch_entry_t       mem_d [FIFO_DEPTH];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, memory credits, redirect squash and prefetch FIFO.
// Optional IF_FETCH_PERF_EN adds fetched/bubble/squashed event counters.
module if_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_STEP  = 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_inst
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [XLEN-1:0]  perf_fetched,
    output logic [XLEN-1:0]  perf_bubbles,
    output logic [XLEN-1:0]  perf_squashed
`endif
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  fly_pc_q, fly_pc_d;
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    logic             inflight_q, inflight_d;
    logic             squash_q, squash_d;

    logic             pop, push, flush, issue;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     resp_entry;

    // Credit check: buffered + landing entries, minus this cycle's pop, must leave room.
    always_comb begin
        out_valid  = (count != '0);
        pop        = out_valid && !stall && !redirect_valid;
        push       = inflight_q && !squash_q;
        flush      = rst || redirect_valid;
        issue      = !rst && !redirect_valid &&
                     ((3'(count) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
        resp_entry = '{pc: fly_pc_q, inst: imem_rdata};

        pc_d       = pc_q;
        fly_pc_d   = fly_pc_q;
        last_pc_d  = last_pc_q;
        inflight_d = issue;
        squash_d   = 1'b0;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            squash_d = inflight_q;
        end else if (issue) begin
            pc_d     = pc_q + PC_STEP;
            fly_pc_d = pc_q;
        end
        if (pop) begin
            last_pc_d = head.pc;
        end

        imem_req  = issue;
        imem_addr = pc_q;
        out_pc    = out_valid ? head.pc   : last_pc_q;
        out_inst  = out_valid ? head.inst : NOP_INST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            fly_pc_q   <= RESET_PC;
            last_pc_q  <= RESET_PC;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            fly_pc_q   <= fly_pc_d;
            last_pc_q  <= last_pc_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (resp_entry),
        .count (count),
        .head  (head)
    );

`ifdef IF_FETCH_PERF_EN
    logic [XLEN-1:0] fetched_q, fetched_d;
    logic [XLEN-1:0] bubbles_q, bubbles_d;
    logic [XLEN-1:0] squashed_q, squashed_d;

    // Dropped work = flushed FIFO entries plus a landing response that is not pushed.
    always_comb begin
        fetched_d  = fetched_q + XLEN'(pop);
        bubbles_d  = bubbles_q + XLEN'(!out_valid && !stall);
        squashed_d = squashed_q
                   + (redirect_valid ? XLEN'(count) : '0)
                   + XLEN'(inflight_q && (redirect_valid || squash_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q  <= '0;
            bubbles_q  <= '0;
            squashed_q <= '0;
        end else begin
            fetched_q  <= fetched_d;
            bubbles_q  <= bubbles_d;
            squashed_q <= squashed_d;
        end
    end

    assign perf_fetched  = fetched_q;
    assign perf_bubbles  = bubbles_q;
    assign perf_squashed = squashed_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus random stall/redirect/reset
// traffic, checked each cycle against a queue-based model of the fetch stage.
module tb_if_fetch;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_pc, imem_rdata, imem_addr, out_pc, out_inst;
    logic        imem_req, out_valid;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles, perf_squashed;
`endif

    int total = 0;
    int bad   = 0;

    // Model: queue of buffered PCs, one in-flight slot, next fetch PC, last popped PC.
    logic [31:0] m_q[$];
    bit          m_fly;
    logic [31:0] m_fly_pc, m_nxt, m_last;
    logic [31:0] p_fetched, p_bubbles, p_squashed;
    logic [96:0] exp_v, act_v;

    if_fetch #(.RESET_PC(RPC), .PC_STEP(32'd1)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles),
        .perf_squashed  (perf_squashed)
`endif
    );

    always #5 clk = ~clk;

    // One-cycle-latency memory; idle cycles return junk so a stray push is visible.
    always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ SALT) : $urandom();

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return a ^ SALT;
    endfunction

    // Apply inputs for this cycle, compute expected outputs, capture actuals, advance model.
    task automatic tick(input bit s, input bit rv, input logic [31:0] rpc, input bit r);
        bit          e_valid, e_req, pop;
        logic [31:0] e_pc, e_inst;
        int          occ;
        stall = s; redirect_valid = rv; redirect_pc = rpc; rst = r;
        #1;
        e_valid = (m_q.size() != 0);
        e_pc    = e_valid ? m_q[0] : m_last;
        e_inst  = e_valid ? mem_of(m_q[0]) : 32'h0;
        pop     = e_valid && !s && !rv;
        occ     = m_q.size() + int'(m_fly) - int'(pop);
        e_req   = !r && !rv && (occ < 2);
        exp_v   = {e_req, e_req ? m_nxt : 32'h0, e_valid, e_pc, e_inst};
        act_v   = {imem_req, imem_req ? imem_addr : 32'h0, out_valid, out_pc, out_inst};
        if (r) begin
            m_q.delete(); m_fly = 0; m_nxt = RPC; m_last = RPC;
            p_fetched = 0; p_bubbles = 0; p_squashed = 0;
        end else if (rv) begin
            p_squashed += 32'(m_q.size()) + 32'(m_fly);
            if (!e_valid && !s) p_bubbles++;
            m_q.delete(); m_fly = 0; m_nxt = rpc;
        end else begin
            if (!e_valid && !s) p_bubbles++;
            if (pop) begin
                m_last = m_q.pop_front();
                p_fetched++;
            end
            if (m_fly) m_q.push_back(m_fly_pc);
            m_fly = e_req;
            if (e_req) begin
                m_fly_pc = m_nxt;
                m_nxt    = m_nxt + 32'd1;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stall = 0; redirect_valid = 0; redirect_pc = 0; rst = 1;
        next_cycle();
        m_q.delete(); m_fly = 0; m_nxt = RPC; m_last = RPC;
        p_fetched = 0; p_bubbles = 0; p_squashed = 0;
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 32'h0, 1);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL reset: got %h want %h", act_v, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_startup();
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 32'h0, 0);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL startup: got %h want %h", act_v, exp_v);
            end
            if (i >= 2) begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== RPC + 32'(i - 2) ||
                    out_inst !== ((RPC + 32'(i - 2)) ^ SALT)) begin
                    bad++;
                    $display("FAIL startup_seq: got v=%b pc=%h inst=%h want pc=%h",
                             out_valid, out_pc, out_inst, RPC + 32'(i - 2));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        int          reqs = 0;
        logic [31:0] held;
        held = out_pc;
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 32'h0, 0);
            if (imem_req === 1'b1) reqs++;
            total++;
            if (act_v !== exp_v || out_pc !== held) begin
                bad++; $display("FAIL stall: got %h want %h held_pc=%h", act_v, exp_v, held);
            end
            next_cycle();
        end
        total++;
        if (reqs > 2) begin
            bad++; $display("FAIL stall_reqs: got %0d requests want at most 2", reqs);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 32'h0, 0);
            total++;
            if (act_v !== exp_v || out_pc !== held + 32'(i)) begin
                bad++; $display("FAIL stall_release: got %h want %h pc=%h", act_v, exp_v, held + 32'(i));
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) tick(0, 1, 32'h40, 0);
            else        tick(0, 0, 32'h0, 0);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL redirect: R+%0d got %h want %h", i, act_v, exp_v);
            end
            if (i == 1 || i == 2) begin
                total++;
                if (out_valid !== 1'b0 || out_inst !== 32'h0) begin
                    bad++; $display("FAIL redirect_nop: R+%0d got v=%b inst=%h want 0/0", i, out_valid, out_inst);
                end
            end
            if (i == 3) begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== (32'h40 ^ SALT)) begin
                    bad++; $display("FAIL redirect_target: got v=%b pc=%h inst=%h want pc=00000040", out_valid, out_pc, out_inst);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect_stall();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) tick(1, 1, 32'h80, 0);
            else        tick(0, 0, 32'h0, 0);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL redir_stall: R+%0d got %h want %h", i, act_v, exp_v);
            end
            if (i == 3) begin
                total++;
                if (out_pc !== 32'h80 || out_valid !== 1'b1) begin
                    bad++; $display("FAIL redir_stall_target: got v=%b pc=%h want pc=00000080", out_valid, out_pc);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect_reset();
        tick(0, 1, 32'h200, 1);
        total++;
        if (act_v !== exp_v) begin
            bad++; $display("FAIL redir_rst: got %h want %h", act_v, exp_v);
        end
        next_cycle();
        tick(0, 0, 32'h0, 0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            bad++; $display("FAIL redir_rst_pc: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RPC);
        end
        next_cycle();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) tick(0, 1, 32'hFFFF_FFFE, 0);
            else        tick(0, 0, 32'h0, 0);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL wrap: R+%0d got %h want %h", i, act_v, exp_v);
            end
            if (i == 3) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                    bad++; $display("FAIL wrap_addr: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom(),
                 $urandom_range(0, 99) == 0);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL random: cycle %0d got %h want %h", i, act_v, exp_v);
            end
            next_cycle();
        end
    endtask

`ifdef IF_FETCH_PERF_EN
    task automatic test_perf();
        tick(0, 0, 32'h0, 1);
        next_cycle();
        for (int i = 0; i < 30; i++) begin
            tick((i % 7) == 5, (i == 14) || (i == 22), 32'h300 + 32'(i), 0);
            next_cycle();
        end
        total++;
        if ({perf_fetched, perf_bubbles, perf_squashed} !== {p_fetched, p_bubbles, p_squashed}) begin
            bad++;
            $display("FAIL perf: got f=%0d b=%0d s=%0d want f=%0d b=%0d s=%0d",
                     perf_fetched, perf_bubbles, perf_squashed, p_fetched, p_bubbles, p_squashed);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_startup_settle();
        test_redirect_stall();
        test_redirect_reset();
        test_wrap();
        test_random();
`ifdef IF_FETCH_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Let the pipe refill after a redirect so the next scenario starts in steady state.
    task automatic test_startup_settle();
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 32'h0, 0);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL settle: got %h want %h", act_v, exp_v);
            end
            next_cycle();
        end
    endtask

endmodule
